// File: rtl/seqdet_feeder_ctrl_if.sv
// Handshake and detector-side signal bundle for seqdet_feeder_ctrl.
// The slave modport is the controller; the master modport is the surrounding system.
interface seqdet_feeder_ctrl_if #(
  parameter int WORD_WIDTH  = 8,
  parameter int COUNT_WIDTH = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WORD_WIDTH-1:0]  in_data;
  logic                   no_clear;
  logic                   det_reset;
  logic                   det_update;
  logic                   det_value;
  logic                   det_detected;
  logic                   result_valid;
  logic                   result_ready;
  logic                   result_hit;
  logic [COUNT_WIDTH-1:0] hit_count;
  logic                   cnt_clear;
  logic                   busy;

  modport slave (
    input  in_valid, in_data, no_clear, det_detected, result_ready, cnt_clear,
    output in_ready, det_reset, det_update, det_value, result_valid, result_hit,
           hit_count, busy
  );

  modport master (
    output in_valid, in_data, no_clear, det_detected, result_ready, cnt_clear,
    input  in_ready, det_reset, det_update, det_value, result_valid, result_hit,
           hit_count, busy
  );
endinterface

// File: rtl/seqdet_feeder_ctrl.sv
// Feeds parallel words MSB-first into a serial sequence detector, then reports
// the sampled sticky detect flag per word and keeps a saturating hit counter.
module seqdet_feeder_ctrl #(
  parameter int WORD_WIDTH  = 8,
  parameter int GAP         = 0,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  seqdet_feeder_ctrl_if.slave bus
);

  localparam int IDX_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_SETTLE,
    S_RESULT
  } state_e;

  state_e                 state_q, state_d;
  logic [WORD_WIDTH-1:0]  shreg_q, shreg_d;
  logic [IDX_W-1:0]       idx_q, idx_d, idx_m1;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic                   in_ready_q, in_ready_d;
  logic                   busy_q, busy_d;
  logic                   det_reset_q, det_reset_d;
  logic                   det_update_q, det_update_d;
  logic                   det_value_q, det_value_d;
  logic                   result_valid_q, result_valid_d;
  logic                   result_hit_q, result_hit_d;
  logic [COUNT_WIDTH-1:0] hit_count_q, hit_count_d;
  logic                   handshake;

  assign idx_m1    = idx_q - IDX_W'(1);
  assign handshake = result_valid_q && bus.result_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      shreg_q        <= '0;
      idx_q          <= '0;
      gap_q          <= '0;
      in_ready_q     <= 1'b1;
      busy_q         <= 1'b0;
      det_reset_q    <= 1'b1;
      det_update_q   <= 1'b0;
      det_value_q    <= 1'b0;
      result_valid_q <= 1'b0;
      result_hit_q   <= 1'b0;
      hit_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      shreg_q        <= shreg_d;
      idx_q          <= idx_d;
      gap_q          <= gap_d;
      in_ready_q     <= in_ready_d;
      busy_q         <= busy_d;
      det_reset_q    <= det_reset_d;
      det_update_q   <= det_update_d;
      det_value_q    <= det_value_d;
      result_valid_q <= result_valid_d;
      result_hit_q   <= result_hit_d;
      hit_count_q    <= hit_count_d;
    end
  end

  // Outputs are registered: each _d describes what the next state must drive.
  // NOTE: every _d gets a default first, so no path leaves one unassigned and
  // no latch is inferred.
  always_comb begin
    state_d        = state_q;
    shreg_d        = shreg_q;
    idx_d          = idx_q;
    gap_d          = gap_q;
    det_reset_d    = 1'b0;
    det_update_d   = 1'b0;
    det_value_d    = det_value_q;
    result_valid_d = result_valid_q;
    result_hit_d   = result_hit_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          shreg_d = bus.in_data;
          idx_d   = IDX_LAST;
          if (bus.no_clear) begin
            state_d      = S_SHIFT;
            det_update_d = 1'b1;
            det_value_d  = bus.in_data[WORD_WIDTH-1];
            gap_d        = GAP_LOAD;
          end else begin
            state_d     = S_CLEAR;
            det_reset_d = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        state_d      = S_SHIFT;
        det_update_d = 1'b1;
        det_value_d  = shreg_q[idx_q];
        gap_d        = GAP_LOAD;
      end
      S_SHIFT: begin
        if (gap_q != '0) begin
          gap_d = gap_q - GAP_W'(1);
        end else if (idx_q == '0) begin
          state_d = S_SETTLE;
        end else begin
          idx_d        = idx_m1;
          det_update_d = 1'b1;
          det_value_d  = shreg_q[idx_m1];
          gap_d        = GAP_LOAD;
        end
      end
      S_SETTLE: begin
        // The flag was registered on the last update edge, so it is valid now.
        state_d        = S_RESULT;
        result_valid_d = 1'b1;
        result_hit_d   = bus.det_detected;
      end
      S_RESULT: begin
        if (bus.result_ready) begin
          state_d        = S_IDLE;
          result_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);

    // Clear beats a coincident increment; the count sticks at all-ones.
    hit_count_d = hit_count_q;
    if (bus.cnt_clear) begin
      hit_count_d = '0;
    end else if (handshake && result_hit_q && !(&hit_count_q)) begin
      hit_count_d = hit_count_q + COUNT_WIDTH'(1);
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.busy         = busy_q;
  assign bus.det_reset    = det_reset_q;
  assign bus.det_update   = det_update_q;
  assign bus.det_value    = det_value_q;
  assign bus.result_valid = result_valid_q;
  assign bus.result_hit   = result_hit_q;
  assign bus.hit_count    = hit_count_q;

endmodule

// File: tb/tb_seqdet_feeder_ctrl.sv
// Bench for seqdet_feeder_ctrl: three instances (default, GAP=2, COUNT_WIDTH=2),
// each driving a behavioural 1011 sticky detector, with a scoreboard of expected hits.
module tb_seqdet_feeder_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seqdet_feeder_ctrl_if #(.WORD_WIDTH(8), .COUNT_WIDTH(8)) if0 ();
  seqdet_feeder_ctrl_if #(.WORD_WIDTH(8), .COUNT_WIDTH(8)) if1 ();
  seqdet_feeder_ctrl_if #(.WORD_WIDTH(8), .COUNT_WIDTH(2)) if2 ();

  seqdet_feeder_ctrl #(.WORD_WIDTH(8), .GAP(0), .COUNT_WIDTH(8))
    u_dut0 (.clk(clk), .reset(reset), .bus(if0));
  seqdet_feeder_ctrl #(.WORD_WIDTH(8), .GAP(2), .COUNT_WIDTH(8))
    u_dut1 (.clk(clk), .reset(reset), .bus(if1));
  seqdet_feeder_ctrl #(.WORD_WIDTH(8), .GAP(0), .COUNT_WIDTH(2))
    u_dut2 (.clk(clk), .reset(reset), .bus(if2));

  // Serial detectors for pattern 1011: sync reset, update strobe, sticky flag.
  logic [3:0] dh0, dh1, dh2;
  logic       df0, df1, df2;

  always_ff @(posedge clk) begin
    if (if0.det_reset) begin
      dh0 <= '0; df0 <= 1'b0;
    end else if (if0.det_update) begin
      dh0 <= {dh0[2:0], if0.det_value};
      if ({dh0[2:0], if0.det_value} == 4'b1011) df0 <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (if1.det_reset) begin
      dh1 <= '0; df1 <= 1'b0;
    end else if (if1.det_update) begin
      dh1 <= {dh1[2:0], if1.det_value};
      if ({dh1[2:0], if1.det_value} == 4'b1011) df1 <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (if2.det_reset) begin
      dh2 <= '0; df2 <= 1'b0;
    end else if (if2.det_update) begin
      dh2 <= {dh2[2:0], if2.det_value};
      if ({dh2[2:0], if2.det_value} == 4'b1011) df2 <= 1'b1;
    end
  end
  assign if0.det_detected = df0;
  assign if1.det_detected = df1;
  assign if2.det_detected = df2;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          q0[$], q1[$], q2[$];
  logic [3:0]  rh[3];
  bit          rs[3];
  int unsigned exp_cnt[3];

  function automatic logic get_ready(int id);
    case (id) 0: return if0.in_ready; 1: return if1.in_ready; default: return if2.in_ready; endcase
  endfunction
  function automatic logic get_valid(int id);
    case (id) 0: return if0.result_valid; 1: return if1.result_valid; default: return if2.result_valid; endcase
  endfunction
  function automatic logic get_hit(int id);
    case (id) 0: return if0.result_hit; 1: return if1.result_hit; default: return if2.result_hit; endcase
  endfunction
  function automatic logic [31:0] get_count(int id);
    case (id) 0: return 32'(if0.hit_count); 1: return 32'(if1.hit_count); default: return 32'(if2.hit_count); endcase
  endfunction
  function automatic logic get_cc(int id);
    case (id) 0: return if0.cnt_clear; 1: return if1.cnt_clear; default: return if2.cnt_clear; endcase
  endfunction
  function automatic bit pop_exp(int id);
    case (id)
      0: return (q0.size() > 0) ? q0.pop_front() : 1'b0;
      1: return (q1.size() > 0) ? q1.pop_front() : 1'b0;
      default: return (q2.size() > 0) ? q2.pop_front() : 1'b0;
    endcase
  endfunction

  task automatic set_in(int id, logic v, logic [7:0] d, logic nc);
    case (id)
      0: begin if0.in_valid = v; if0.in_data = d; if0.no_clear = nc; end
      1: begin if1.in_valid = v; if1.in_data = d; if1.no_clear = nc; end
      default: begin if2.in_valid = v; if2.in_data = d; if2.no_clear = nc; end
    endcase
  endtask
  task automatic set_rr(int id, logic r);
    case (id) 0: if0.result_ready = r; 1: if1.result_ready = r; default: if2.result_ready = r; endcase
  endtask
  task automatic set_cc(int id, logic c);
    case (id) 0: if0.cnt_clear = c; 1: if1.cnt_clear = c; default: if2.cnt_clear = c; endcase
  endtask

  // Reference: bit stream since the last clear, MSB first, sticky on 1011.
  task automatic push_expected(int id, logic [7:0] w, bit nc);
    if (!nc) begin rh[id] = '0; rs[id] = 1'b0; end
    for (int i = 7; i >= 0; i--) begin
      rh[id] = {rh[id][2:0], w[i]};
      if (rh[id] == 4'b1011) rs[id] = 1'b1;
    end
    case (id) 0: q0.push_back(rs[id]); 1: q1.push_back(rs[id]); default: q2.push_back(rs[id]); endcase
  endtask

  task automatic reset_models();
    q0.delete(); q1.delete(); q2.delete();
    for (int i = 0; i < 3; i++) begin rh[i] = '0; rs[i] = 1'b0; exp_cnt[i] = 0; end
  endtask

  // Called and returns at a negedge; returns in the cycle after the accept edge.
  task automatic send_word(int id, logic [7:0] w, bit nc);
    int k;
    push_expected(id, w, nc);
    k = 0;
    while (get_ready(id) !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    if (k >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL send%0d in_ready timeout got %b required 1", id, get_ready(id));
    end
    set_in(id, 1'b1, w, nc);
    @(negedge clk);
    set_in(id, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic recv_result(int id, string name, int delay);
    int k;
    bit exp;
    k = 0;
    while (get_valid(id) !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    exp = pop_exp(id);
    n_checks++;
    if (get_valid(id) !== 1'b1) begin
      n_fail++;
      $display("FAIL %s result_valid timeout got %b required 1", name, get_valid(id));
      return;
    end
    repeat (delay) @(negedge clk);
    n_checks++;
    if (get_hit(id) !== exp) begin
      n_fail++;
      $display("FAIL %s result_hit got %b required %b", name, get_hit(id), exp);
    end
    set_rr(id, 1'b1);
    @(negedge clk);
    set_rr(id, 1'b0);
    if (get_cc(id)) exp_cnt[id] = 0;
    else if (exp && exp_cnt[id] < ((id == 2) ? 3 : 255)) exp_cnt[id]++;
    n_checks++;
    if (get_count(id) !== exp_cnt[id]) begin
      n_fail++;
      $display("FAIL %s hit_count got %0d required %0d", name, get_count(id), exp_cnt[id]);
    end
    n_checks++;
    if (get_valid(id) !== 1'b0) begin
      n_fail++;
      $display("FAIL %s result_valid after handshake got %b required 0", name, get_valid(id));
    end
  endtask

  task automatic check_reset_values(string name);
    logic [8:0] got;
    got = {if0.in_ready, if0.det_reset, if0.det_update, if0.det_value, if0.result_valid,
           if0.result_hit, if0.busy, (if0.hit_count == 8'd0), (if2.hit_count == 2'd0)};
    n_checks++;
    if (got !== 9'b1_1000_0011) begin
      n_fail++;
      $display("FAIL %s outputs {rdy,drst,upd,val,vld,hit,busy,cnt0,cnt2} got %b required 110000011",
               name, got);
    end
  endtask

  task automatic test_reset();
    set_in(0, 1'b0, 8'h00, 1'b0); set_in(1, 1'b0, 8'h00, 1'b0); set_in(2, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin set_rr(i, 1'b0); set_cc(i, 1'b0); end
    reset_models();
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    #1;
    n_checks++;
    if (if0.det_reset !== 1'b1) begin
      n_fail++; $display("FAIL reset_release det_reset got %b required 1", if0.det_reset);
    end
    @(negedge clk);
    n_checks++;
    if (if0.det_reset !== 1'b0 || if0.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_idle det_reset/in_ready got %b/%b required 0/1", if0.det_reset, if0.in_ready);
    end
  endtask

  task automatic test_basic();
    logic [7:0] w;
    w = 8'b0010_1100;
    send_word(0, w, 1'b0);
    n_checks++;
    if ({if0.det_reset, if0.det_update, if0.in_ready, if0.busy} !== 4'b1001) begin
      n_fail++;
      $display("FAIL basic_clear {drst,upd,rdy,busy} got %b required 1001",
               {if0.det_reset, if0.det_update, if0.in_ready, if0.busy});
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (if0.det_update !== 1'b1 || if0.det_value !== w[7-i] || if0.det_reset !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_bit%0d upd/val got %b/%b required 1/%b", i, if0.det_update,
                 if0.det_value, w[7-i]);
      end
    end
    @(negedge clk);
    n_checks++;
    if (if0.det_update !== 1'b0 || if0.result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_settle upd/vld got %b/%b required 0/0", if0.det_update, if0.result_valid);
    end
    @(negedge clk);
    n_checks++;
    if (if0.result_valid !== 1'b1) begin
      n_fail++; $display("FAIL basic_latency result_valid got %b required 1", if0.result_valid);
    end
    recv_result(0, "basic", 0);
  endtask

  task automatic test_no_hit();
    send_word(0, 8'hFF, 1'b0);
    recv_result(0, "no_hit_ff", 1);
    send_word(0, 8'h00, 1'b0);
    recv_result(0, "no_hit_00", 0);
    set_rr(0, 1'b1);
    @(negedge clk);
    set_rr(0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (if0.result_valid !== 1'b0 || 32'(if0.hit_count) !== exp_cnt[0] || if0.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_ready vld/cnt/rdy got %b/%0d/%b required 0/%0d/1", if0.result_valid,
               if0.hit_count, if0.in_ready, exp_cnt[0]);
    end
  endtask

  task automatic test_span();
    send_word(0, 8'b0000_0101, 1'b0);
    recv_result(0, "span_first", 0);
    send_word(0, 8'b1000_0000, 1'b1);
    n_checks++;
    if ({if0.det_reset, if0.det_update, if0.det_value} !== 3'b011) begin
      n_fail++;
      $display("FAIL span_noclear {drst,upd,val} got %b required 011",
               {if0.det_reset, if0.det_update, if0.det_value});
    end
    recv_result(0, "span_second", 0);
    send_word(0, 8'h00, 1'b1);
    recv_result(0, "sticky", 2);
    send_word(0, 8'h00, 1'b0);
    recv_result(0, "sticky_cleared", 0);
  endtask

  task automatic test_gap();
    logic [7:0] w;
    w = 8'hA5;
    send_word(1, w, 1'b0);
    n_checks++;
    if (if1.det_reset !== 1'b1) begin
      n_fail++; $display("FAIL gap_clear det_reset got %b required 1", if1.det_reset);
    end
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      n_checks++;
      if (if1.det_update !== ((k % 3) == 0) || if1.det_value !== w[7 - k/3]) begin
        n_fail++;
        $display("FAIL gap_cycle%0d upd/val got %b/%b required %b/%b", k, if1.det_update,
                 if1.det_value, ((k % 3) == 0), w[7 - k/3]);
      end
    end
    @(negedge clk);
    n_checks++;
    if (if1.det_update !== 1'b0 || if1.result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_settle upd/vld got %b/%b required 0/0", if1.det_update, if1.result_valid);
    end
    @(negedge clk);
    n_checks++;
    if (if1.result_valid !== 1'b1) begin
      n_fail++; $display("FAIL gap_latency result_valid got %b required 1", if1.result_valid);
    end
    set_in(1, 1'b1, 8'h2C, 1'b0);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      n_checks++;
      if (if1.result_valid !== 1'b1 || if1.result_hit !== q1[0] || if1.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL gap_stall%0d vld/hit/rdy got %b/%b/%b required 1/%b/0", s,
                 if1.result_valid, if1.result_hit, if1.in_ready, q1[0]);
      end
    end
    set_in(1, 1'b0, 8'h00, 1'b0);
    recv_result(1, "gap_a5", 0);
    send_word(1, 8'h2C, 1'b0);
    recv_result(1, "gap_2c", 1);
  endtask

  task automatic test_saturate();
    for (int n = 0; n < 4; n++) begin
      send_word(2, 8'b0010_1100, 1'b0);
      recv_result(2, $sformatf("sat%0d", n), 0);
    end
    send_word(2, 8'b0010_1100, 1'b0);
    set_cc(2, 1'b1);
    recv_result(2, "sat_clear_wins", 0);
    set_cc(2, 1'b0);
    send_word(2, 8'b0010_1100, 1'b0);
    recv_result(2, "sat_after_clear", 0);
    set_cc(0, 1'b1);
    @(negedge clk);
    set_cc(0, 1'b0);
    exp_cnt[0] = 0;
    n_checks++;
    if (32'(if0.hit_count) !== 32'd0) begin
      n_fail++; $display("FAIL cnt_clear hit_count got %0d required 0", if0.hit_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    bit nc;
    for (int n = 0; n < 16; n++) begin
      w  = ((n % 3) == 0) ? 8'b0010_1100 : 8'($urandom);
      nc = 1'($urandom_range(0, 1));
      send_word(0, w, nc);
      recv_result(0, $sformatf("b2b%0d", n), int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] w;
    send_word(0, 8'b0010_1100, 1'b0);
    recv_result(0, "mid_pre", 0);
    w = 8'hB3;
    send_word(0, w, 1'b0);
    repeat (4) @(negedge clk);
    n_checks++;
    if (if0.det_update !== 1'b1 || if0.det_value !== w[4]) begin
      n_fail++;
      $display("FAIL mid_bit4 upd/val got %b/%b required 1/%b", if0.det_update, if0.det_value, w[4]);
    end
    #1 reset = 1'b1;
    #1 check_reset_values("mid_reset");
    reset_models();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send_word(0, 8'b0010_1100, 1'b0);
    recv_result(0, "mid_after", 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_hit();
    test_span();
    test_gap();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seqdet_feeder_ctrl.md
Name: seqdet_feeder_ctrl

Overview:
Controller that sequences the serial sequence-detector datapath, which has a 1-bit value input, an update strobe, a synchronous reset and a sticky registered detect flag. It accepts parallel words over a valid/ready handshake, optionally clears the detector, then shifts the word out MSB-first as gated update strobes. It samples the detect flag once the last bit has been absorbed, returns a per-word hit result over a second valid/ready handshake, and keeps a saturating hit counter.

Parameters:
WORD_WIDTH, 8, bits per input word; must be at least 1.
GAP, 0, idle cycles inserted after each update strobe; must be at least 0.
COUNT_WIDTH, 8, width of hit_count.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset for all controller state.
in_valid  input  1  in_data/no_clear valid.
in_ready  output  1  high only in IDLE.
in_data  input  WORD_WIDTH  word to scan; bit WORD_WIDTH-1 is sent first.
no_clear  input  1  sampled at accept; 1 = skip detector clear, so the pattern may span words.
det_reset  output  1  drives the detector synchronous reset.
det_update  output  1  drives the detector update strobe.
det_value  output  1  drives the detector value bit.
det_detected  input  1  detector sticky detect flag.
result_valid  output  1  result available.
result_ready  input  1  consumer accepts the result.
result_hit  output  1  det_detected as sampled for the current word.
hit_count  output  COUNT_WIDTH  number of accepted results with hit=1.
cnt_clear  input  1  synchronous clear of hit_count.
busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset values (async assert): state=IDLE, in_ready=1, det_reset=1, det_update=0, det_value=0, result_valid=0, result_hit=0, hit_count=0, busy=0.
- det_reset stays 1 in the first clock after reset deasserts, so the detector is cleared.
- All outputs are registered.
- State IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_data into the shift register, latch no_clear, load bit index = WORD_WIDTH-1.
  - Next state is CLEAR if no_clear=0, else SHIFT.
- State CLEAR: lasts exactly 1 cycle with det_reset=1, det_update=0; then goes to SHIFT.
- State SHIFT:
  - On update cycles: det_update=1 and det_value=current bit.
  - After each update cycle, insert GAP cycles with det_update=0; det_value holds its last value.
  - After the update cycle for bit 0 (plus its GAP cycles), go to SETTLE.
- State SETTLE:
  - 1 cycle, det_update=0.
  - Purpose: the detector registers its flag on the same edge as the last update, so det_detected is valid during SETTLE.
  - At the SETTLE exit edge: result_hit <= det_detected, result_valid <= 1. Next state is RESULT.
- State RESULT:
  - Hold result_valid and result_hit stable until result_ready=1.
  - On result_valid&result_ready: result_valid <= 0, state <= IDLE.
  - hit_count increments if result_hit=1, saturating at all-ones (never wraps).
- Latency, GAP=0, no_clear=0:
  - Accept edge T; det_reset high in cycle T+1.
  - Updates in cycles T+2..T+WORD_WIDTH+1; SETTLE in T+WORD_WIDTH+2; result_valid from T+WORD_WIDTH+3.
  - With no_clear=1, every step after T is 1 cycle earlier.
- Total update cycles per word = WORD_WIDTH×(1+GAP).
- Since the detect flag is sticky, with no_clear=1 result_hit stays 1 once any earlier word hit, until a word with no_clear=0 is processed.
- hit_count rules:
  - cnt_clear=1 sets hit_count=0 at the next edge.
  - Simultaneous cnt_clear and increment: the clear wins (count=0).
- in_valid is ignored outside IDLE.
- result_ready is ignored when result_valid=0.
- Reset asserted mid-operation: immediately return to the reset values above. The partial word and the pending result are discarded, and hit_count is cleared.

Test Plan:
- Reset, then in_data=8'b0010_1100, no_clear=0, GAP=0 → det_reset 1 cycle; det_value sequence 0,0,1,0,1,1,0,0 with det_update=1 for 8 consecutive cycles; result_hit=1 at T+11; hit_count=1 after handshake.
- in_data=8'hFF, then 8'h00, both with no_clear=0 → result_hit=0 for each; hit_count unchanged.
- Word 8'b0000_0101 with no_clear=0, then 8'b1000_0000 with no_clear=1 (1011 spans the boundary) → first result_hit=0, second result_hit=1.
- GAP=2, word 8'hA5 → 8 update pulses each separated by 2 low cycles (24 cycles total); result_valid at T+27; result_ready held low for 5 cycles → result_valid/result_hit stable, in_ready=0.
- COUNT_WIDTH=2, 4 hitting words (8'b0010_1100) → hit_count 1,2,3,3 (saturates); cnt_clear together with a hit handshake → 0.
- Assert reset during SHIFT bit 4 → all outputs return to reset values immediately (async); the next word is processed normally with a correct result.
